// File: rtl/fp_wb_pkg.sv
// rtl/fp_wb_pkg.sv - source codes and default widths shared by the FP writeback arbiter
package fp_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 5;
  localparam int CNT_W_DEF  = 16;

  // Codes double as bit positions in the valid/grant vectors.
  typedef enum logic [1:0] {
    SRC_DM   = 2'b00,
    SRC_MOV  = 2'b01,
    SRC_NORM = 2'b10
  } src_e;

  function automatic src_e src_after(input src_e s);
    case (s)
      SRC_DM:  return SRC_MOV;
      SRC_MOV: return SRC_NORM;
      default: return SRC_DM;
    endcase
  endfunction

endpackage

// File: rtl/fp_wb_rr_arb3.sv
// rtl/fp_wb_rr_arb3.sv - three-way grant select; round-robin pointer when FP_WB_RR_EN is defined,
// otherwise fixed priority norm > dm > mov with no state
module fp_wb_rr_arb3
  import fp_wb_pkg::*;
(
`ifdef FP_WB_RR_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic       block_i,
  input  logic [2:0] valid_i,
  output logic [2:0] grant_o,
  output src_e       grant_src_o
);

`ifdef FP_WB_RR_EN
  src_e ptr_q, ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= SRC_NORM;
    else     ptr_q <= ptr_d;
  end

  always_comb begin
    src_e cand;
    logic found;
    grant_o     = '0;
    grant_src_o = SRC_DM;
    found       = 1'b0;
    cand        = src_after(ptr_q);
    for (int k = 0; k < 3; k++) begin
      if (!block_i && !found && valid_i[cand]) begin
        grant_o[cand] = 1'b1;
        grant_src_o   = cand;
        found         = 1'b1;
      end
      cand = src_after(cand);
    end
  end

  // Pointer only moves on a real transfer so a stalled cycle keeps fairness intact.
  assign ptr_d = (|grant_o) ? grant_src_o : ptr_q;
`else
  always_comb begin
    grant_o     = '0;
    grant_src_o = SRC_NORM;
    if (!block_i) begin
      if (valid_i[SRC_NORM]) begin
        grant_o[SRC_NORM] = 1'b1;
        grant_src_o       = SRC_NORM;
      end else if (valid_i[SRC_DM]) begin
        grant_o[SRC_DM] = 1'b1;
        grant_src_o     = SRC_DM;
      end else if (valid_i[SRC_MOV]) begin
        grant_o[SRC_MOV] = 1'b1;
        grant_src_o      = SRC_MOV;
      end
    end
  end
`endif

endmodule

// File: rtl/fp_wb_arbiter.sv
// rtl/fp_wb_arbiter.sv - merges dm/mov/norm results into one registered FP/INT writeback stage
// with a saturating contention counter; FP_WB_RR_EN selects round-robin arbitration
module fp_wb_arbiter
  import fp_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_valid,
  output logic              dm_ready,
  input  logic [DATA_W-1:0] dm_data,
  input  logic [RD_W-1:0]   dm_rd,
  input  logic              dm_fp_en,
  input  logic              dm_int_en,
  input  logic              mov_valid,
  output logic              mov_ready,
  input  logic [DATA_W-1:0] mov_data,
  input  logic [RD_W-1:0]   mov_rd,
  input  logic              mov_fp_en,
  input  logic              mov_int_en,
  input  logic              norm_valid,
  output logic              norm_ready,
  input  logic [DATA_W-1:0] norm_data,
  input  logic [RD_W-1:0]   norm_rd,
  input  logic              norm_fp_en,
  input  logic              norm_int_en,
  input  logic              wb_stall,
  output logic              wb_valid,
  output logic [1:0]        wb_sel,
  output logic [RD_W-1:0]   wb_rd,
  output logic              fp_we,
  output logic              int_we,
  output logic [DATA_W-1:0] fp_wdata,
  output logic [DATA_W-1:0] int_wdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic [2:0]        valid, grant;
  src_e              grant_src;
  logic              transfer, contended;
  logic [DATA_W-1:0] sel_data;
  logic [RD_W-1:0]   sel_rd;
  logic              sel_fp_en, sel_int_en;

  logic              wb_valid_q, wb_valid_d;
  src_e              wb_sel_q, wb_sel_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic              fp_we_q, fp_we_d, int_we_q, int_we_d;
  logic [DATA_W-1:0] fp_wdata_q, fp_wdata_d, int_wdata_q, int_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign valid = {norm_valid, mov_valid, dm_valid};

  fp_wb_rr_arb3 u_arb (
`ifdef FP_WB_RR_EN
    .clk         (clk),
    .rst         (rst),
`endif
    .block_i     (wb_stall | rst),
    .valid_i     (valid),
    .grant_o     (grant),
    .grant_src_o (grant_src)
  );

  assign dm_ready   = grant[SRC_DM];
  assign mov_ready  = grant[SRC_MOV];
  assign norm_ready = grant[SRC_NORM];
  assign transfer   = |grant;
  assign contended  = (dm_valid & mov_valid) | (dm_valid & norm_valid) | (mov_valid & norm_valid);

  always_comb begin
    case (grant_src)
      SRC_DM:  begin sel_data = dm_data;   sel_rd = dm_rd;   sel_fp_en = dm_fp_en;   sel_int_en = dm_int_en;   end
      SRC_MOV: begin sel_data = mov_data;  sel_rd = mov_rd;  sel_fp_en = mov_fp_en;  sel_int_en = mov_int_en;  end
      default: begin sel_data = norm_data; sel_rd = norm_rd; sel_fp_en = norm_fp_en; sel_int_en = norm_int_en; end
    endcase
  end

  always_comb begin
    wb_valid_d  = wb_valid_q;
    wb_sel_d    = wb_sel_q;
    wb_rd_d     = wb_rd_q;
    fp_we_d     = fp_we_q;
    int_we_d    = int_we_q;
    fp_wdata_d  = fp_wdata_q;
    int_wdata_d = int_wdata_q;
    if (!wb_stall) begin
      if (transfer) begin
        wb_valid_d  = 1'b1;
        wb_sel_d    = grant_src;
        wb_rd_d     = sel_rd;
        fp_we_d     = sel_fp_en;
        int_we_d    = sel_int_en;
        fp_wdata_d  = sel_fp_en  ? sel_data : '0;
        int_wdata_d = sel_int_en ? sel_data : '0;
      end else begin
        // Bubble: sel/rd keep their last value, only the write qualifiers drop.
        wb_valid_d  = 1'b0;
        fp_we_d     = 1'b0;
        int_we_d    = 1'b0;
        fp_wdata_d  = '0;
        int_wdata_d = '0;
      end
    end
    cnt_d = cnt_q;
    if (transfer && contended && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q  <= 1'b0;
      wb_sel_q    <= SRC_DM;
      wb_rd_q     <= '0;
      fp_we_q     <= 1'b0;
      int_we_q    <= 1'b0;
      fp_wdata_q  <= '0;
      int_wdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_sel_q    <= wb_sel_d;
      wb_rd_q     <= wb_rd_d;
      fp_we_q     <= fp_we_d;
      int_we_q    <= int_we_d;
      fp_wdata_q  <= fp_wdata_d;
      int_wdata_q <= int_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_sel       = wb_sel_q;
  assign wb_rd        = wb_rd_q;
  assign fp_we        = fp_we_q;
  assign int_we       = int_we_q;
  assign fp_wdata     = fp_wdata_q;
  assign int_wdata    = int_wdata_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb/tb_fp_wb_arbiter.sv - directed self-checking bench for fp_wb_arbiter (both FP_WB_RR_EN builds)
module tb_fp_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        dm_valid, dm_ready, dm_fp_en, dm_int_en;
  logic [31:0] dm_data;
  logic [4:0]  dm_rd;
  logic        mov_valid, mov_ready, mov_fp_en, mov_int_en;
  logic [31:0] mov_data;
  logic [4:0]  mov_rd;
  logic        norm_valid, norm_ready, norm_fp_en, norm_int_en;
  logic [31:0] norm_data;
  logic [4:0]  norm_rd;
  logic        wb_stall, wb_valid, fp_we, int_we;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_rd;
  logic [31:0] fp_wdata, int_wdata;
  logic [2:0]  conflict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Narrow counter so saturation is reachable in a few cycles.
  fp_wb_arbiter #(.DATA_W(32), .RD_W(5), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .dm_valid(dm_valid), .dm_ready(dm_ready), .dm_data(dm_data), .dm_rd(dm_rd),
    .dm_fp_en(dm_fp_en), .dm_int_en(dm_int_en),
    .mov_valid(mov_valid), .mov_ready(mov_ready), .mov_data(mov_data), .mov_rd(mov_rd),
    .mov_fp_en(mov_fp_en), .mov_int_en(mov_int_en),
    .norm_valid(norm_valid), .norm_ready(norm_ready), .norm_data(norm_data), .norm_rd(norm_rd),
    .norm_fp_en(norm_fp_en), .norm_int_en(norm_int_en),
    .wb_stall(wb_stall), .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_rd(wb_rd),
    .fp_we(fp_we), .int_we(int_we), .fp_wdata(fp_wdata), .int_wdata(int_wdata),
    .conflict_cnt(conflict_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    dm_valid = 0; mov_valid = 0; norm_valid = 0;
    dm_fp_en = 0; dm_int_en = 0; mov_fp_en = 0; mov_int_en = 0;
    norm_fp_en = 0; norm_int_en = 0;
  endtask

  initial begin
    logic [1:0] exp_sel;
    logic [2:0] exp_rdy;
    rst = 1'b1; wb_stall = 1'b0;
    idle();
    dm_data = '0; dm_rd = '0; mov_data = '0; mov_rd = '0; norm_data = '0; norm_rd = '0;
    dm_valid = 1'b1;
    #3;
    chk("rst_dm_ready", dm_ready, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_fp_wdata", fp_wdata, 0);
    #4;
    dm_valid = 1'b0;
    rst = 1'b0;
    step();

    // single norm source
    norm_valid = 1; norm_data = 32'h3F800000; norm_rd = 7; norm_fp_en = 1;
    #1;
    chk("a_rdy", {norm_ready, mov_ready, dm_ready}, 3'b100);
    step();
    idle();
    chk("a_wb_valid", wb_valid, 1);
    chk("a_wb_sel", wb_sel, 2'b10);
    chk("a_wb_rd", wb_rd, 7);
    chk("a_fp_we", fp_we, 1);
    chk("a_int_we", int_we, 0);
    chk("a_fp_wdata", fp_wdata, 32'h3F800000);
    chk("a_int_wdata", int_wdata, 0);
    chk("a_cnt", conflict_cnt, 0);
    step();
    chk("bub_wb_valid", wb_valid, 0);
    chk("bub_fp_we", fp_we, 0);
    chk("bub_fp_wdata", fp_wdata, 0);
    chk("bub_wb_sel_hold", wb_sel, 2'b10);
    chk("bub_wb_rd_hold", wb_rd, 7);

    // all three contending for three cycles
    dm_valid = 1;   dm_data = 32'h11111111;   dm_rd = 1;    dm_int_en = 1;
    mov_valid = 1;  mov_data = 32'h22222222;  mov_rd = 2;   mov_fp_en = 1;
    norm_valid = 1; norm_data = 32'h40000000; norm_rd = 12; norm_fp_en = 1;
    for (int c = 0; c < 3; c++) begin
`ifdef FP_WB_RR_EN
      exp_sel = c[1:0];
`else
      exp_sel = 2'b10;
`endif
      exp_rdy = 3'b001 << exp_sel;
      #1;
      chk($sformatf("b_rdy%0d", c), {norm_ready, mov_ready, dm_ready}, exp_rdy);
      step();
      chk($sformatf("b_sel%0d", c), wb_sel, exp_sel);
    end
    chk("b_cnt", conflict_cnt, 3);
    idle();

    // stall holds outputs and blocks dm
    dm_valid = 1; dm_data = 32'hAAAA0001; dm_rd = 3; dm_int_en = 1;
    wb_stall = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("c_dm_ready_stall%0d", c), dm_ready, 0);
      step();
      chk($sformatf("c_hold_valid%0d", c), wb_valid, 1);
      chk($sformatf("c_hold_sel%0d", c), wb_sel, 2'b10);
      chk($sformatf("c_hold_rd%0d", c), wb_rd, 12);
      chk($sformatf("c_hold_fp_wdata%0d", c), fp_wdata, 32'h40000000);
    end
    wb_stall = 0;
    #1;
    chk("c_dm_ready", dm_ready, 1);
    step();
    idle();
    chk("c_sel", wb_sel, 2'b00);
    chk("c_rd", wb_rd, 3);
    chk("c_int_we", int_we, 1);
    chk("c_fp_we", fp_we, 0);
    chk("c_int_wdata", int_wdata, 32'hAAAA0001);
    chk("c_fp_wdata", fp_wdata, 0);
    chk("c_cnt", conflict_cnt, 3);

    // dual write from mov
    mov_valid = 1; mov_data = 32'h12345678; mov_rd = 9; mov_fp_en = 1; mov_int_en = 1;
    #1;
    chk("d_mov_ready", mov_ready, 1);
    step();
    idle();
    chk("d_sel", wb_sel, 2'b01);
    chk("d_rd", wb_rd, 9);
    chk("d_we", {fp_we, int_we}, 2'b11);
    chk("d_fp_wdata", fp_wdata, 32'h12345678);
    chk("d_int_wdata", int_wdata, 32'h12345678);

    // no enables: still a transfer, zero data
    dm_valid = 1; dm_data = 32'hFFFFFFFF; dm_rd = 1;
    step();
    idle();
    chk("e_wb_valid", wb_valid, 1);
    chk("e_sel", wb_sel, 2'b00);
    chk("e_we", {fp_we, int_we}, 2'b00);
    chk("e_fp_wdata", fp_wdata, 0);
    chk("e_int_wdata", int_wdata, 0);

    // async reset mid-cycle with counter at 5
    dm_valid = 1; mov_valid = 1;
    step();
    step();
    chk("f_cnt_pre", conflict_cnt, 5);
    chk("f_valid_pre", wb_valid, 1);
    norm_valid = 1;
    #2;
    rst = 1;
    #1;
    chk("f_rst_valid", wb_valid, 0);
    chk("f_rst_cnt", conflict_cnt, 0);
    chk("f_rst_sel_rd", {wb_sel, wb_rd}, 0);
    chk("f_rst_we", {fp_we, int_we}, 0);
    chk("f_rst_data", {fp_wdata, int_wdata}, 0);
    chk("f_rst_rdy", {norm_ready, mov_ready, dm_ready}, 0);
    rst = 0;
    #1;
`ifdef FP_WB_RR_EN
    exp_sel = 2'b00;
`else
    exp_sel = 2'b10;
`endif
    chk("f_first_rdy", {norm_ready, mov_ready, dm_ready}, 3'b001 << exp_sel);
    step();
    chk("f_first_sel", wb_sel, exp_sel);
    chk("f_cnt1", conflict_cnt, 1);

    // counter saturation at all-ones
    for (int c = 0; c < 6; c++) step();
    chk("g_cnt_max", conflict_cnt, 7);
    step();
    chk("g_cnt_sat", conflict_cnt, 7);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
